// File: rtl/pls_pio_ctrl.sv
// Avalon-MM general-purpose I/O: per-bit direction, set/clear writes, synchronised inputs, edge capture, maskable irq.
// Optional timed output pulses at addresses 6/7 when PLS_PIO_PULSE_EN is defined.
module pls_pio_ctrl #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_evt;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic             irq_q, irq_d;

`ifdef PLS_PIO_PULSE_EN
  logic [15:0]      plen_q, plen_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic             pulse_wr;
  logic             pulse_expire;

  assign pulse_wr     = wr_en && (address == 3'd7);
  // A fresh PULSE write reloads the counter, so it suppresses expiry of the running pulse.
  assign pulse_expire = (|pmask_q) && (pcnt_q == 16'd0) && !pulse_wr;
`endif

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_TYPE == 1) begin : g_fall
      assign edge_evt = ~sync & prev_q;
    end else if (EDGE_TYPE == 2) begin : g_any
      assign edge_evt = sync ^ prev_q;
    end else begin : g_rise
      assign edge_evt = sync & ~prev_q;
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    // Capture is OR-ed in after the clear so a coincident event keeps its bit set.
    ecap_d = (ecap_q & ~((wr_en && (address == 3'd3)) ? wdata : '0)) | edge_evt;
    irq_d  = |(ecap_q & mask_q);
`ifdef PLS_PIO_PULSE_EN
    plen_d  = plen_q;
    pcnt_d  = pcnt_q;
    pmask_d = pmask_q;
    if (pulse_expire) begin
      data_d  = data_q & ~pmask_q;
      pmask_d = '0;
    end else if ((|pmask_q) && !pulse_wr) begin
      pcnt_d = pcnt_q - 16'd1;
    end
`endif
    if (wr_en) begin
      case (address)
        3'd0: data_d = wdata;
        3'd1: dir_d  = wdata;
        3'd2: mask_d = wdata;
        3'd4: data_d = data_d | wdata;
        3'd5: data_d = data_d & ~wdata;
`ifdef PLS_PIO_PULSE_EN
        3'd6: plen_d = writedata[15:0];
        3'd7: begin
          data_d  = data_d | wdata;
          pmask_d = pmask_q | wdata;
          pcnt_d  = plen_q;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      data_q <= RESET_VALUE;
      dir_q  <= RESET_DIR;
      mask_q <= '0;
      ecap_q <= '0;
      irq_q  <= 1'b0;
`ifdef PLS_PIO_PULSE_EN
      plen_q  <= '0;
      pcnt_q  <= '0;
      pmask_q <= '0;
`endif
    end else begin
      sync_q[0] <= pio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync;
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      ecap_q <= ecap_d;
      irq_q  <= irq_d;
`ifdef PLS_PIO_PULSE_EN
      plen_q  <= plen_d;
      pcnt_q  <= pcnt_d;
      pmask_q <= pmask_d;
`endif
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        3'd0: readdata[WIDTH-1:0] = (data_q & dir_q) | (sync & ~dir_q);
        3'd1: readdata[WIDTH-1:0] = dir_q;
        3'd2: readdata[WIDTH-1:0] = mask_q;
        3'd3: readdata[WIDTH-1:0] = ecap_q;
`ifdef PLS_PIO_PULSE_EN
        3'd6: readdata[15:0] = plen_q;
        3'd7: readdata[WIDTH-1:0] = pmask_q;
`endif
        default: readdata = '0;
      endcase
    end
  end

  assign pio_out = data_q;
  assign pio_oe  = dir_q;
  assign irq     = irq_q;

endmodule

// File: doc/pls_pio_ctrl.md
Name: pls_pio_ctrl

Overview:
Parametrised Avalon-MM general-purpose I/O block. It generalises our single-bit output ports (such as the OTG HPI chip-select control) to WIDTH bidirectional bits. Each bit has a direction control, atomic set/clear writes, synchronised input sampling, edge capture and a maskable interrupt. It sits on the system interconnect as an s1-style slave. It drives board-level control or status pins.

Parameters:
WIDTH, 8, number of I/O bits; legal range 1..32.
RESET_VALUE, 0, reset value of the output data register (WIDTH bits).
RESET_DIR, 0, reset value of the direction register; 1 = output.
EDGE_TYPE, 0, edge-capture mode: 0 rising, 1 falling, 2 any edge.
SYNC_STAGES, 2, input synchroniser depth; minimum 2.

Ports:
clk  input  1  system clock; sole clock.
reset  input  1  asynchronous, active-high reset.
address  input  3  register word address.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
writedata  input  32  write data; bits above WIDTH are ignored.
readdata  output  32  read data; combinational, zero wait states; bits above WIDTH read 0.
pio_in  input  WIDTH  external pin inputs; asynchronous to clk.
pio_out  output  WIDTH  output data register.
pio_oe  output  WIDTH  output enable; equals the direction register.
irq  output  1  level interrupt.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high, named reset.
- Register map (word addresses):
  - 0 DATA. Write loads data_out. Read returns, per bit: data_out where dir=1, synced input where dir=0.
  - 1 DIR. Read/write.
  - 2 IRQMASK. Read/write.
  - 3 EDGECAP. Read returns captured edges. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 4 OUTSET. Write ORs writedata into data_out. Reads 0.
  - 5 OUTCLR. Write clears the bits set in writedata. Reads 0.
  - 6, 7: reserved, or pulse registers when the optional feature is enabled. Reserved addresses read 0 and ignore writes.
- Reset values: data_out=RESET_VALUE, dir=RESET_DIR, irqmask=0, edgecap=0, synchroniser flops=0, irq=0.
  - pio_out=RESET_VALUE and pio_oe=RESET_DIR while reset is asserted.
- Write latency: register updates are visible on pio_out/pio_oe one clk after the write cycle.
- Read timing: readdata is combinational from address. When chipselect=0, readdata is 0.
- Input path: pio_in passes through a SYNC_STAGES flop chain; the last stage is sync. A further flop holds prev.
- Edge detect, evaluated on all bits regardless of dir:
  - rising: sync & ~prev
  - falling: ~sync & prev
  - any: sync ^ prev
- Edge latency: a pin change is reflected in EDGECAP SYNC_STAGES+1 clks after it meets setup at the first stage.
- Simultaneous edge event and write-1-to-clear on the same bit: the event wins and the bit stays 1.
- irq = |(edgecap & irqmask), registered, so irq asserts one clk after edgecap updates.
  - irq deasserts one clk after the last contributing bit is cleared or masked.
- Reset mid-operation: all state returns to reset values asynchronously. Pending edges are discarded.
  - After reset deasserts, synchroniser contents are 0. A pin held high then produces a rising edge on the first synced cycle; this is intended.

Optional Feature:
Macro PLS_PIO_PULSE_EN.
- Defined:
  - Address 6 PULSELEN: 16-bit read/write, reset 0.
  - Address 7 PULSE: a write sets data_out bits in writedata and loads a 16-bit down-counter with PULSELEN.
  - The counter decrements each clk. When it reaches 0, the pulsed bits are cleared in data_out.
  - Result: the bits stay high for PULSELEN+1 clks.
  - PULSELEN=0 gives a 1-clk pulse.
  - A new PULSE write while a pulse is active ORs in its bits and reloads the counter.
  - A DATA/OUTCLR write to a pulsed bit in the expiry cycle: the write wins.
  - Reading PULSE returns the active pulse mask.
- Undefined: addresses 6 and 7 are reserved. No counter logic is present.

Test Plan:
- Reset with RESET_VALUE=8'hA5, RESET_DIR=8'h0F -> pio_out=A5, pio_oe=0F, irq=0, EDGECAP reads 0.
- DATA write 8'h3C, then OUTSET 8'h01, then OUTCLR 8'h0C -> pio_out sequence 3C, 3D, 31, each one clk after its write.
- dir=0, EDGE_TYPE=0, IRQMASK=8'h04; drive pio_in[2] 0->1 -> EDGECAP=8'h04 after 3 clks; irq=1 one clk later. Write EDGECAP 8'h04 -> irq=0 after 2 clks.
- Rising edge on bit 2 in the same cycle as an EDGECAP clear write of 8'h04 -> EDGECAP stays 8'h04.
- EDGE_TYPE=2; toggle pio_in[7] 1->0 with IRQMASK=0 -> EDGECAP bit 7 set, irq stays 0. Setting IRQMASK=8'h80 -> irq=1.
- With PLS_PIO_PULSE_EN: PULSELEN=4, PULSE write 8'h10 -> pio_out[4] high for exactly 5 clks. Assert reset mid-pulse -> pio_out=RESET_VALUE immediately.
